// File: rtl/cpu_pkg.sv
// cpu_pkg: shared 8008 register-bank definitions (register indices,
// execute-unit op codes, regbank arbiter state encoding).
package cpu_pkg;

    localparam int unsigned RB_AW = 3;
    localparam int unsigned RB_DW = 8;

    // Register indices of the 8008 register set; M is a memory pseudo-register
    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;
    localparam logic [2:0] REG_D = 3'd3;
    localparam logic [2:0] REG_E = 3'd4;
    localparam logic [2:0] REG_H = 3'd5;
    localparam logic [2:0] REG_L = 3'd6;
    localparam logic [2:0] REG_M = 3'd7;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_INC = 2'b10,
        OP_DCR = 2'b11
    } exe_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXE  = 3'd1,
        ST_MRL  = 3'd2,
        ST_MRH  = 3'd3,
        ST_ACK  = 3'd4
    } arb_state_e;

    // M cannot be accessed through the bank; every other index is a real register
    function automatic logic is_bank_reg(input logic [2:0] idx);
        return idx != REG_M;
    endfunction

endpackage

// File: rtl/cpu_regbank_arb_pri.sv
// cpu_regbank_arb_pri: grant decision between EXE and MEM requesters.
// Optional macro REGBANK_ARB_RR_EN: round-robin with a priority pointer
// (reset favours MEM); undefined: MEM always wins over EXE.
module cpu_regbank_arb_pri
    import cpu_pkg::*;
(
`ifdef REGBANK_ARB_RR_EN
    input  logic CLK_I,
    input  logic RST_I,
`endif
    input  logic idle_i,
    input  logic exe_req_i,
    input  logic mem_req_i,
    output logic exe_gnt_o,
    output logic mem_gnt_o
);

`ifdef REGBANK_ARB_RR_EN
    // High when MEM wins the next contested grant
    logic mem_pri_q;

    // Contested grants go to the side that was not granted last
    always_comb begin
        mem_gnt_o = idle_i & mem_req_i & (~exe_req_i | mem_pri_q);
        exe_gnt_o = idle_i & exe_req_i & (~mem_req_i | ~mem_pri_q);
    end

    // Pointer hands priority to the other side after every grant
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mem_pri_q <= 1'b1;
        end else if (mem_gnt_o) begin
            mem_pri_q <= 1'b0;
        end else if (exe_gnt_o) begin
            mem_pri_q <= 1'b1;
        end
    end
`else
    // Fixed priority: MEM always beats EXE
    always_comb begin
        mem_gnt_o = idle_i & mem_req_i;
        exe_gnt_o = idle_i & exe_req_i & ~mem_req_i;
    end
`endif

endmodule

// File: rtl/cpu_regbank_arb.sv
// cpu_regbank_arb: sequencer sharing the 8008 register bank between the
// execute unit (single register RD/WR/INC/DCR) and the memory-address unit
// (L then H read forming the 14-bit M address). Sole driver of the bank.
// Optional macro REGBANK_ARB_RR_EN selects round-robin arbitration.
module cpu_regbank_arb
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            EXE_REQ_I,
    input  logic [1:0]      EXE_OP_I,
    input  logic [AW-1:0]   EXE_ADDR_I,
    input  logic [DW-1:0]   EXE_DAT_I,
    output logic            EXE_ACK_O,
    output logic            EXE_ERR_O,
    output logic [DW-1:0]   EXE_DAT_O,
    input  logic            MEM_REQ_I,
    output logic            MEM_ACK_O,
    output logic [DW+5:0]   MEM_ADDR_O,
    output logic            RB_RD_O,
    output logic            RB_WR_O,
    output logic            RB_INC_O,
    output logic            RB_DCR_O,
    output logic [AW-1:0]   RB_ADDR_O,
    output logic [DW-1:0]   RB_DAT_O,
    input  logic [DW-1:0]   RB_DAT_I
);

    arb_state_e    state_q;
    exe_op_e       op_q;
    logic [DW-1:0] l_q;
    logic          exe_gnt;
    logic          mem_gnt;
    logic          idle;

    assign idle = (state_q == ST_IDLE);

    cpu_regbank_arb_pri u_pri (
`ifdef REGBANK_ARB_RR_EN
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
`endif
        .idle_i    (idle),
        .exe_req_i (EXE_REQ_I),
        .mem_req_i (MEM_REQ_I),
        .exe_gnt_o (exe_gnt),
        .mem_gnt_o (mem_gnt)
    );

    // Sequencer FSM with all bank strobes and handshake outputs registered.
    // The EXE address and write data are held in RB_ADDR_O/RB_DAT_O for the
    // whole operation, so only the op code needs its own latch.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RD;
            l_q        <= '0;
            EXE_ACK_O  <= 1'b0;
            EXE_ERR_O  <= 1'b0;
            EXE_DAT_O  <= '0;
            MEM_ACK_O  <= 1'b0;
            MEM_ADDR_O <= '0;
            RB_RD_O    <= 1'b0;
            RB_WR_O    <= 1'b0;
            RB_INC_O   <= 1'b0;
            RB_DCR_O   <= 1'b0;
            RB_ADDR_O  <= '0;
            RB_DAT_O   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_gnt) begin
                        RB_RD_O   <= 1'b1;
                        RB_ADDR_O <= REG_L;
                        state_q   <= ST_MRL;
                    end else if (exe_gnt) begin
                        op_q      <= exe_op_e'(EXE_OP_I);
                        RB_ADDR_O <= EXE_ADDR_I;
                        RB_DAT_O  <= EXE_DAT_I;
                        if (is_bank_reg(EXE_ADDR_I)) begin
                            case (exe_op_e'(EXE_OP_I))
                                OP_RD:  RB_RD_O  <= 1'b1;
                                OP_WR:  RB_WR_O  <= 1'b1;
                                OP_INC: RB_INC_O <= 1'b1;
                                OP_DCR: RB_DCR_O <= 1'b1;
                            endcase
                        end
                        state_q <= ST_EXE;
                    end
                end
                ST_EXE: begin
                    RB_RD_O   <= 1'b0;
                    RB_WR_O   <= 1'b0;
                    RB_INC_O  <= 1'b0;
                    RB_DCR_O  <= 1'b0;
                    EXE_ACK_O <= 1'b1;
                    if (!is_bank_reg(RB_ADDR_O)) begin
                        EXE_ERR_O <= 1'b1;
                        EXE_DAT_O <= '0;
                    end else if (op_q == OP_WR) begin
                        EXE_DAT_O <= RB_DAT_O;
                    end else begin
                        // bank updates on this same edge, so this is the pre-op value
                        EXE_DAT_O <= RB_DAT_I;
                    end
                    state_q <= ST_ACK;
                end
                ST_MRL: begin
                    l_q       <= RB_DAT_I;
                    RB_ADDR_O <= REG_H;
                    state_q   <= ST_MRH;
                end
                ST_MRH: begin
                    RB_RD_O    <= 1'b0;
                    MEM_ADDR_O <= {RB_DAT_I[5:0], l_q};
                    MEM_ACK_O  <= 1'b1;
                    state_q    <= ST_ACK;
                end
                ST_ACK: begin
                    EXE_ACK_O <= 1'b0;
                    EXE_ERR_O <= 1'b0;
                    MEM_ACK_O <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
